prio_encoder_rr: RTL and testbench

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

---
 rtl/prio_enc_pkg.sv | 19 +
 rtl/prio_scan.sv | 30 +++
 rtl/prio_encoder_rr.sv | 91 +++++++++
 tb/tb_prio_encoder_rr.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the round-robin / fixed priority encoder:
// arbitration mode encodings and the index-width helper.
package prio_enc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational priority scan: finds the highest (hi_first=1) or lowest
// (hi_first=0) set bit of vec.
module prio_scan
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic         hi_first,
  output logic         found,
  output logic [W-1:0] index
);

  always_comb begin
    found = |vec;
    index = '0;
    if (hi_first) begin
      // ascending sweep: the last hit is the highest set bit
      for (int unsigned i = 0; i < N; i++) begin
        if (vec[i]) index = W'(i);
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (vec[N-1-k]) index = W'(N - 1 - k);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed (highest index) or round-robin
// arbitration and a valid/ready output handshake.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         out_valid,
  output logic         any
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] ptr_q;
  logic [W-1:0] idx_q;
  logic         valid_q;
  logic         load;
  logic         rr_sel;

  logic [N-1:0] rr_mask;
  logic [N-1:0] req_masked;
  logic         masked_found;
  logic [W-1:0] masked_idx;
  logic         full_found;
  logic [W-1:0] full_idx;
  logic [W-1:0] winner;
  logic [W-1:0] ptr_next;

  assign rr_sel = (mode_e'(mode) == MODE_RR);
  assign load   = !valid_q || out_ready;

  always_comb begin
    rr_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rr_mask[i] = (W'(i) >= ptr_q);
    end
  end

  assign req_masked = req & rr_mask;

  prio_scan #(.N(N), .W(W)) u_scan_masked (
    .vec      (req_masked),
    .hi_first (1'b0),
    .found    (masked_found),
    .index    (masked_idx)
  );

  // Full-vector scan doubles as the round-robin wrap-around search
  // (low-first) and the fixed-priority search (high-first).
  prio_scan #(.N(N), .W(W)) u_scan_full (
    .vec      (req),
    .hi_first (!rr_sel),
    .found    (full_found),
    .index    (full_idx)
  );

  always_comb begin
    winner = full_idx;
    if (rr_sel && masked_found) winner = masked_idx;
  end

  assign ptr_next = (winner == LAST) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (load) begin
      if (full_found) begin
        idx_q   <= winner;
        valid_q <= 1'b1;
        ptr_q   <= ptr_next;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign idx       = idx_q;
  assign out_valid = valid_q;
  assign any       = full_found;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: directed vectors push expected
// (idx, ptr) pairs; monitors pop them when a result is accepted.
module tb_prio_encoder_rr;

  typedef struct {
    logic [2:0] idx;
    logic [2:0] ptr;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic       out_ready;
  logic [2:0] idx;
  logic       out_valid;
  logic       any;

  logic [4:0] req5;
  logic       mode5;
  logic       rdy5;
  logic [2:0] idx5;
  logic       valid5;
  logic       any5;

  res_t sb[$];
  res_t sb5[$];

  int checks = 0;
  int errors = 0;

  prio_encoder_rr #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .out_ready (out_ready),
    .idx       (idx),
    .out_valid (out_valid),
    .any       (any)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req5),
    .mode      (mode5),
    .out_ready (rdy5),
    .idx       (idx5),
    .out_valid (valid5),
    .any       (any5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic m, input logic rdy);
    req       = r;
    mode      = m;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input int p);
    res_t e;
    e.idx = 3'(i);
    e.ptr = 3'(p);
    sb.push_back(e);
  endtask

  // Monitor for the N=8 instance: a result is consumed when valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result8", 1, 0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("idx8", int'(idx), int'(e.idx));
        chk("ptr8", int'(dut.ptr_q), int'(e.ptr));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid5 && rdy5) begin
      if (sb5.size() == 0) begin
        chk("unexpected_result5", 1, 0);
      end else begin
        res_t e;
        e = sb5.pop_front();
        chk("idx5", int'(idx5), int'(e.idx));
        chk("ptr5", int'(dut5.ptr_q), int'(e.ptr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    req5      = '0;
    mode5     = 1'b1;
    rdy5      = 1'b1;

    // Reset state and combinational any
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_ptr", int'(dut.ptr_q), 0);
    chk("rst_any0", int'(any), 0);
    req = 8'h81;
    #1;
    chk("rst_any1", int'(any), 1);
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin sweep with all requests held: 0..7 then 0
    for (int i = 0; i < 9; i++) begin
      push(i % 8, (i + 1) % 8);
      drive(8'hFF, 1'b1, 1'b1);
    end

    // Fixed priority picks the highest index; ptr still advances
    push(3, 4);
    drive(8'b0000_1100, 1'b0, 1'b1);
    // Mode change keeps ptr=4: lowest set index >= 4 is 7
    push(7, 0);
    drive(8'b1000_0001, 1'b1, 1'b1);
    push(6, 7);
    drive(8'b0110_0001, 1'b0, 1'b1);
    // ptr=7, nothing at or above it: wrap to lowest set index
    push(5, 6);
    drive(8'b0010_0000, 1'b1, 1'b1);
    push(1, 2);
    drive(8'b0000_0010, 1'b1, 1'b1);

    // Idle: no requests drops valid, holds idx and ptr
    drive(8'h00, 1'b1, 1'b1);
    chk("idle_valid", int'(out_valid), 0);
    chk("idle_idx", int'(idx), 1);
    chk("idle_ptr", int'(dut.ptr_q), 2);
    chk("idle_any", int'(any), 0);

    // Stall: result 5 held for 3 cycles while req changes
    push(5, 6);
    drive(8'b0010_0000, 1'b1, 1'b1);
    drive(8'hFF, 1'b1, 1'b0);
    chk("stall_idx_a", int'(idx), 5);
    chk("stall_any", int'(any), 1);
    drive(8'h01, 1'b1, 1'b0);
    chk("stall_idx_b", int'(idx), 5);
    drive(8'h80, 1'b1, 1'b0);
    chk("stall_idx_c", int'(idx), 5);
    chk("stall_valid", int'(out_valid), 1);
    chk("stall_ptr", int'(dut.ptr_q), 6);
    // Released: ptr=6, only bit 3 set, wrap-around winner 3
    push(3, 4);
    drive(8'b0000_1000, 1'b1, 1'b1);
    drive(8'h00, 1'b1, 1'b1);

    // Reset pulse mid-stall discards the pending result asynchronously
    push(2, 3);
    drive(8'h04, 1'b0, 1'b1);
    out_ready = 1'b0;
    req       = 8'h10;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_idx", int'(idx), 0);
    chk("arst_ptr", int'(dut.ptr_q), 0);
    sb.delete();
    #3;
    rst_n = 1'b1;
    // First edge after release loads: ptr=0, bit 6 only
    push(6, 7);
    drive(8'h40, 1'b1, 1'b1);
    drive(8'h00, 1'b1, 1'b1);

    // N=5 round-robin sweep: ptr wraps 4 -> 0
    for (int i = 0; i < 6; i++) begin
      res_t e;
      e.idx = 3'(i % 5);
      e.ptr = 3'((i + 1) % 5);
      sb5.push_back(e);
      req5 = 5'b11111;
      @(posedge clk);
      #1;
    end
    req5 = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("sb8_drained", sb.size(), 0);
    chk("sb5_drained", sb5.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
